// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: multi-cycle add/subtract that reuses one DIGIT-wide
// adder slice over WIDTH/DIGIT cycles, with a registered inter-digit carry,
// signed-overflow detection and a start/done handshake.
module chunked_serial_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;       // operand A, consumed from the low digit upward
  logic [WIDTH-1:0] b_sh;       // operand B (already inverted for subtract)
  logic [WIDTH-1:0] part;       // partial sum, filled from the top downward
  logic             a_msb;      // sign bits kept for the overflow check
  logic             b_msb;
  logic             carry_reg;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   dig;        // {carry, digit sum} of the current slice
  logic [WIDTH-1:0] next_part;

  // One DIGIT-wide slice plus the partial sum with the new digit shifted in.
  // After N shifts the digit processed first sits at the bottom of the word.
  always_comb begin
    dig       = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
              + (DIGIT+1)'(carry_reg);
    next_part = (part >> DIGIT) | (WIDTH'(dig[DIGIT-1:0]) << (WIDTH - DIGIT));
  end

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      carry_reg <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      part      <= '0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh      <= x;
            b_sh      <= sub ? ~y : y;
            carry_reg <= sub ? ~carry_in : carry_in;
            a_msb     <= x[WIDTH-1];
            b_msb     <= sub ? ~y[WIDTH-1] : y[WIDTH-1];
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          a_sh      <= a_sh >> DIGIT;
          b_sh      <= b_sh >> DIGIT;
          part      <= next_part;
          carry_reg <= dig[DIGIT];
          cnt       <= cnt + CW'(1);
          if (cnt == LAST) begin
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            sum       <= next_part;
            carry_out <= dig[DIGIT];
            overflow  <= (a_msb == b_msb) && (next_part[WIDTH-1] != a_msb);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench for chunked_serial_adder: directed vectors, protocol
// scenarios and randomized operations over four configurations, compared
// against an integer-arithmetic reference model.
module tb_chunked_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_v [4];
  logic        sub_v   [4];
  logic        cin_v   [4];
  logic [31:0] x_v     [4];
  logic [31:0] y_v     [4];
  logic        busy_v  [4];
  logic        done_v  [4];
  logic        co_v    [4];
  logic        ov_v    [4];
  logic [7:0]  sum0;
  logic [7:0]  sum1;
  logic [31:0] sum2;
  logic [6:0]  sum3;

  int checks   = 0;
  int failures = 0;
  int unsigned wt [4] = '{8, 8, 32, 7};
  int unsigned nt [4] = '{4, 1, 8, 7};

  chunked_serial_adder #(.WIDTH(8), .DIGIT(2)) u_w8d2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub_v[0]),
    .x(x_v[0][7:0]), .y(y_v[0][7:0]), .carry_in(cin_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum0),
    .carry_out(co_v[0]), .overflow(ov_v[0]));

  chunked_serial_adder #(.WIDTH(8), .DIGIT(8)) u_w8d8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub_v[1]),
    .x(x_v[1][7:0]), .y(y_v[1][7:0]), .carry_in(cin_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum1),
    .carry_out(co_v[1]), .overflow(ov_v[1]));

  chunked_serial_adder #(.WIDTH(32), .DIGIT(4)) u_w32d4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub_v[2]),
    .x(x_v[2]), .y(y_v[2]), .carry_in(cin_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum2),
    .carry_out(co_v[2]), .overflow(ov_v[2]));

  chunked_serial_adder #(.WIDTH(7), .DIGIT(1)) u_w7d1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .sub(sub_v[3]),
    .x(x_v[3][6:0]), .y(y_v[3][6:0]), .carry_in(cin_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .sum(sum3),
    .carry_out(co_v[3]), .overflow(ov_v[3]));

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_sum(input int idx);
    case (idx)
      0:       return 32'(sum0);
      1:       return 32'(sum1);
      2:       return sum2;
      default: return 32'(sum3);
    endcase
  endfunction

  function automatic logic [31:0] mask_of(input int idx);
    return (wt[idx] == 32) ? 32'hFFFF_FFFF : ((32'd1 << wt[idx]) - 32'd1);
  endfunction

  // Reference: true unsigned/signed integer results of X+Y+cin or X-Y-cin.
  task automatic model(input int idx, input logic s, input logic [31:0] xa,
                       input logic [31:0] ya, input logic ci,
                       output logic [31:0] rs, output logic rco, output logic rov);
    longint m, ux, uy, sx, sy, c, ru, rsg;
    m  = longint'(1) << wt[idx];
    ux = longint'(xa & mask_of(idx));
    uy = longint'(ya & mask_of(idx));
    c  = ci ? 1 : 0;
    sx = (ux >= m / 2) ? ux - m : ux;
    sy = (uy >= m / 2) ? uy - m : uy;
    if (s) begin
      ru  = ux - uy - c;
      rco = (ux >= uy + c);
      rsg = sx - sy - c;
    end else begin
      ru  = ux + uy + c;
      rco = (ru >= m);
      rsg = sx + sy + c;
    end
    rs  = 32'(ru & (m - 1));
    rov = (rsg < -(m / 2)) || (rsg >= m / 2);
  endtask

  function automatic logic [31:0] pick(input int idx);
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return mask_of(idx);
      2:       return 32'd1 << (wt[idx] - 1);
      3:       return (32'd1 << (wt[idx] - 1)) - 32'd1;
      default: return $urandom & mask_of(idx);
    endcase
  endfunction

  // One complete operation: latency, hold of old result, latching, results.
  task automatic run_op(input int idx, input logic s, input logic [31:0] xa,
                        input logic [31:0] ya, input logic ci,
                        output logic [31:0] rs, output logic rco, output logic rov);
    logic [31:0] held, es;
    logic        eco, eov;
    int          cyc;
    @(negedge clk);
    start_v[idx] = 1'b1;
    sub_v[idx]   = s;
    x_v[idx]     = xa & mask_of(idx);
    y_v[idx]     = ya & mask_of(idx);
    cin_v[idx]   = ci;
    held = get_sum(idx);
    @(posedge clk); #1;
    check("busy_set", 64'(busy_v[idx]), 64'd1);
    @(negedge clk);
    start_v[idx] = 1'b0;
    x_v[idx]     = $urandom & mask_of(idx);
    y_v[idx]     = $urandom & mask_of(idx);
    sub_v[idx]   = 1'($urandom);
    cin_v[idx]   = 1'($urandom);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (!done_v[idx] && cyc < 64) check("sum_hold", 64'(get_sum(idx)), 64'(held));
    end while (!done_v[idx] && cyc < 64);
    if (!done_v[idx]) check("done_timeout", 64'd0, 64'd1);
    check("latency", 64'(cyc), 64'(nt[idx]));
    check("busy_clr", 64'(busy_v[idx]), 64'd0);
    model(idx, s, xa, ya, ci, es, eco, eov);
    rs  = get_sum(idx);
    rco = co_v[idx];
    rov = ov_v[idx];
    check("sum", 64'(rs), 64'(es));
    check("carry_out", 64'(rco), 64'(eco));
    check("overflow", 64'(rov), 64'(eov));
    @(posedge clk); #1;
    check("done_pulse", 64'(done_v[idx]), 64'd0);
  endtask

  task automatic directed(input logic s, input logic [31:0] xa, input logic [31:0] ya,
                          input logic ci, input logic [7:0] e_s, input logic e_co,
                          input logic e_ov);
    logic [31:0] rs;
    logic        rco, rov;
    run_op(0, s, xa, ya, ci, rs, rco, rov);
    check("dir_sum", 64'(rs), 64'(e_s));
    check("dir_co", 64'(rco), 64'(e_co));
    check("dir_ov", 64'(rov), 64'(e_ov));
  endtask

  initial begin
    logic [31:0] rs, es;
    logic        rco, rov, eco, eov;
    int          dones, last_done;

    // Reset with start asserted: reset must dominate.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start_v[i] = 1'b1; sub_v[i] = 1'b0; cin_v[i] = 1'b0;
      x_v[i] = 32'd0; y_v[i] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rst_busy", 64'(busy_v[i]), 64'd0);
      check("rst_done", 64'(done_v[i]), 64'd0);
      check("rst_sum", 64'(get_sum(i)), 64'd0);
      check("rst_co", 64'(co_v[i]), 64'd0);
      check("rst_ov", 64'(ov_v[i]), 64'd0);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) start_v[i] = 1'b0;
    rst_n = 1'b1;

    // Directed vectors on the 8-bit, 2-bit-digit instance.
    directed(1'b0, 32'h3C, 32'h5A, 1'b0, 8'h96, 1'b0, 1'b1);
    directed(1'b0, 32'hFF, 32'h01, 1'b1, 8'h01, 1'b1, 1'b0);
    directed(1'b0, 32'h7F, 32'h00, 1'b1, 8'h80, 1'b0, 1'b1);
    directed(1'b1, 32'h10, 32'h20, 1'b0, 8'hF0, 1'b0, 1'b0);
    directed(1'b1, 32'h80, 32'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
    directed(1'b1, 32'h05, 32'h05, 1'b1, 8'hFF, 1'b0, 1'b0);

    // START re-pulsed with other operands while busy: ignored.
    @(negedge clk);
    start_v[0] = 1'b1; sub_v[0] = 1'b0; x_v[0] = 32'h3C; y_v[0] = 32'h5A; cin_v[0] = 1'b0;
    @(posedge clk);
    dones = 0; last_done = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start_v[0] = (c < 4);
      if (c < 4) begin
        x_v[0] = $urandom & 32'hFF; y_v[0] = $urandom & 32'hFF; sub_v[0] = 1'($urandom);
      end
      @(posedge clk); #1;
      if (done_v[0]) begin dones++; last_done = c; end
    end
    check("repulse_dones", 64'(dones), 64'd1);
    check("repulse_latency", 64'(last_done), 64'd4);
    check("repulse_sum", 64'(sum0), 64'h96);

    // START held high: one completion every N+1 cycles.
    @(negedge clk);
    start_v[0] = 1'b1; sub_v[0] = 1'b1; x_v[0] = 32'h11; y_v[0] = 32'h22; cin_v[0] = 1'b1;
    model(0, 1'b1, 32'h11, 32'h22, 1'b1, es, eco, eov);
    dones = 0; last_done = -1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done_v[0]) begin
        if (last_done >= 0) check("held_gap", 64'(c - last_done), 64'd5);
        else check("held_first", 64'(c), 64'd4);
        check("held_sum", 64'(sum0), 64'(es));
        dones++;
        last_done = c;
      end
    end
    check("held_dones", 64'(dones), 64'd6);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(posedge clk);

    // Reset in the middle of a run: abort, no DONE, outputs cleared.
    run_op(0, 1'b0, 32'h11, 32'h22, 1'b0, rs, rco, rov);
    check("pre_rst_sum", 64'(rs), 64'h33);
    @(negedge clk);
    start_v[0] = 1'b1; x_v[0] = 32'hFF; y_v[0] = 32'hFF; sub_v[0] = 1'b0; cin_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 64'(busy_v[0]), 64'd0);
    check("abort_sum", 64'(sum0), 64'd0);
    check("abort_done", 64'(done_v[0]), 64'd0);
    check("abort_co", 64'(co_v[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done_v[0]) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);

    // Randomized operations on every configuration.
    for (int idx = 0; idx < 4; idx++) begin
      for (int n = 0; n < 150; n++) begin
        run_op(idx, 1'($urandom), pick(idx), pick(idx), 1'($urandom), rs, rco, rov);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
